// File: rtl/matrix_mac_row_pipe.sv
// Two-stage broadcast multiply-add across PARALLEL_NUM lanes with valid/ready flow control.
// Each lane's result register doubles as its accumulator for row/dot-product accumulation.
module matrix_mac_row_pipe #(
    parameter int PARALLEL_NUM = 28,
    parameter int DATA_W       = 16,
    parameter int SAT_EN       = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_acc,
    input  logic                           in_first,
    input  logic [DATA_W-1:0]              mula,
    input  logic [PARALLEL_NUM*DATA_W-1:0] mulb_set,
    input  logic [PARALLEL_NUM*DATA_W-1:0] addc_set,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PARALLEL_NUM*DATA_W-1:0] result,
    output logic [PARALLEL_NUM-1:0]        out_ovf
);

    localparam int PW = 2 * DATA_W;

    logic                    en;
    logic                    v1;
    logic                    acc1;
    logic                    first1;
    logic [PW-1:0]           prod1 [PARALLEL_NUM];
    logic [DATA_W-1:0]       c1    [PARALLEL_NUM];
    logic [DATA_W-1:0]       res_q [PARALLEL_NUM];
    logic [DATA_W-1:0]       res_n [PARALLEL_NUM];
    logic [PARALLEL_NUM-1:0] ovf_q;
    logic [PARALLEL_NUM-1:0] ovf_n;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign out_ovf  = ovf_q;

    for (genvar i = 0; i < PARALLEL_NUM; i++) begin : g_lane
        logic [DATA_W-1:0] addend;
        logic [PW:0]       sum;

        // Accumulate mode feeds back the last produced result, wrapped or saturated.
        always_comb begin
            addend = c1[i];
            if (acc1) begin
                addend = first1 ? '0 : res_q[i];
            end
            sum      = {1'b0, prod1[i]} + (PW+1)'(addend);
            ovf_n[i] = |sum[PW:DATA_W];
            res_n[i] = sum[DATA_W-1:0];
            if (SAT_EN != 0 && ovf_n[i]) begin
                res_n[i] = '1;
            end
        end

        assign result[i*DATA_W +: DATA_W] = res_q[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            acc1   <= 1'b0;
            first1 <= 1'b0;
            for (int i = 0; i < PARALLEL_NUM; i++) begin
                prod1[i] <= '0;
                c1[i]    <= '0;
            end
        end else if (en) begin
            v1 <= in_valid;
            if (in_valid) begin
                acc1   <= in_acc;
                first1 <= in_first;
                for (int i = 0; i < PARALLEL_NUM; i++) begin
                    prod1[i] <= PW'(mula) * PW'(mulb_set[i*DATA_W +: DATA_W]);
                    c1[i]    <= addc_set[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Bubbles drop out_valid but keep result, preserving the accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            ovf_q     <= '0;
            for (int i = 0; i < PARALLEL_NUM; i++) begin
                res_q[i] <= '0;
            end
        end else if (en) begin
            out_valid <= v1;
            if (v1) begin
                ovf_q <= ovf_n;
                for (int i = 0; i < PARALLEL_NUM; i++) begin
                    res_q[i] <= res_n[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_mac_row_pipe.sv
// Directed bench for matrix_mac_row_pipe: wrap and saturating instances share stimulus.
// Expected values are hand-computed constants.
module tb_matrix_mac_row_pipe;

    localparam int PN = 4;
    localparam int DW = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_acc = 1'b0;
    logic           in_first = 1'b0;
    logic           out_ready = 1'b1;
    logic [DW-1:0]  mula = '0;
    logic [63:0]    mulb_set = '0;
    logic [63:0]    addc_set = '0;

    logic           in_ready;
    logic           out_valid;
    logic [63:0]    result;
    logic [PN-1:0]  out_ovf;
    logic           in_ready_s;
    logic           out_valid_s;
    logic [63:0]    result_s;
    logic [PN-1:0]  out_ovf_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matrix_mac_row_pipe #(.PARALLEL_NUM(PN), .DATA_W(DW), .SAT_EN(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_acc(in_acc), .in_first(in_first),
        .mula(mula), .mulb_set(mulb_set), .addc_set(addc_set),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_ovf(out_ovf)
    );

    matrix_mac_row_pipe #(.PARALLEL_NUM(PN), .DATA_W(DW), .SAT_EN(1)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .in_acc(in_acc), .in_first(in_first),
        .mula(mula), .mulb_set(mulb_set), .addc_set(addc_set),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .result(result_s), .out_ovf(out_ovf_s)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic acc, input logic first);
        mula     = a;
        mulb_set = b;
        addc_set = c;
        in_acc   = acc;
        in_first = first;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int sent;
        int got;
        bit stalled;
        bit acc_now;
        bit con_now;
        logic [63:0] held;

        // Reset state
        #12 rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_ovf", 64'(out_ovf), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        step();

        // T1 basic
        beat(16'd3, {16'hFFFF, 16'd1, 16'd0, 16'd5}, {16'd0, 16'd0, 16'd1, 16'd7}, 1'b0, 1'b0);
        check("t1_lat1_valid", 64'(out_valid), 64'd0);
        step();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_result", result, 64'hFFFD_0003_0001_0016);
        check("t1_ovf", 64'(out_ovf), 64'h8);
        check("t1_sat_lane3", 64'(result_s[63:48]), 64'hFFFF);
        step();
        check("t1_drain", 64'(out_valid), 64'd0);

        // T2 overflow: wrap vs saturate, ovf not sticky
        beat(16'h0100, {48'd0, 16'h0100}, {48'd0, 16'd1}, 1'b0, 1'b0);
        step();
        check("t2_wrap_result", result, 64'h0000_0000_0000_0001);
        check("t2_wrap_ovf", 64'(out_ovf), 64'h1);
        check("t2_sat_result", result_s, 64'h0000_0000_0000_FFFF);
        check("t2_sat_ovf", 64'(out_ovf_s), 64'h1);
        step();

        // T3 back-to-back accumulate
        beat(16'd2, {48'd0, 16'd3}, 64'd0, 1'b1, 1'b1);
        beat(16'd2, {48'd0, 16'd4}, 64'd0, 1'b1, 1'b0);
        check("t3_acc0", 64'(result[15:0]), 64'd6);
        beat(16'd1, {48'd0, 16'd10}, 64'd0, 1'b1, 1'b0);
        check("t3_acc1", 64'(result[15:0]), 64'd14);
        step();
        check("t3_acc2", 64'(result[15:0]), 64'd24);
        check("t3_acc2_valid", 64'(out_valid), 64'd1);
        step();
        step();

        // T4 backpressure stream, lane0 = b0 + c0 = 11*(n+1)
        sent = 0;
        got = 0;
        stalled = 0;
        held = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (sent < 5);
            in_acc    = 1'b0;
            in_first  = 1'b0;
            mula      = 16'd1;
            mulb_set  = {48'd0, 16'(sent + 1)};
            addc_set  = {48'd0, 16'(10 * (sent + 1))};
            #1;
            if (!out_ready && out_valid) begin
                check("t4_in_ready", 64'(in_ready), 64'd0);
                if (stalled) check("t4_hold", result, held);
                held = result;
                stalled = 1;
            end else begin
                stalled = 0;
            end
            acc_now = in_valid && in_ready;
            con_now = out_valid && out_ready;
            if (con_now) begin
                check("t4_order", 64'(result[15:0]), 64'(11 * (got + 1)));
                got++;
            end
            step();
            if (acc_now) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("t4_count", 64'(got), 64'd5);

        // T5 asynchronous reset with two beats in flight
        beat(16'd1, {48'd0, 16'd5}, {48'd0, 16'd5}, 1'b0, 1'b0);
        beat(16'd1, {48'd0, 16'd6}, {48'd0, 16'd6}, 1'b0, 1'b0);
        check("t5_pre_result", 64'(result[15:0]), 64'd10);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_result", result, 64'd0);
        check("t5_rst_ovf", 64'(out_ovf), 64'd0);
        #3 rst = 1'b0;
        step();
        check("t5_no_ghost", 64'(out_valid), 64'd0);
        beat(16'd2, {48'd0, 16'd3}, 64'd0, 1'b1, 1'b0);
        step();
        check("t5_acc_after_rst", 64'(result[15:0]), 64'd6);
        step();

        // T6 accumulate across bubbles
        beat(16'd2, {48'd0, 16'd3}, 64'd0, 1'b1, 1'b1);
        step();
        check("t6_v_a", 64'(out_valid), 64'd1);
        check("t6_res_a", 64'(result[15:0]), 64'd6);
        beat(16'd2, {48'd0, 16'd4}, 64'd0, 1'b1, 1'b0);
        check("t6_gap_valid", 64'(out_valid), 64'd0);
        check("t6_gap_hold", 64'(result[15:0]), 64'd6);
        step();
        check("t6_v_b", 64'(out_valid), 64'd1);
        check("t6_res_b", 64'(result[15:0]), 64'd14);
        step();
        check("t6_drain", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
